// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: DEPTH-deep chain of WIDTH-bit pipeline registers with
// per-stage valid, valid/ready backpressure, per-stage stall and flush.
// Latency DEPTH cycles, throughput 1/cycle; in_ready is combinational from
// the tail back to stage 0, so a draining chain accepts every cycle.
// Optional perf counters: define PIPE_STAGE_CHAIN_PERF_EN.
module pipe_stage_chain #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic [DEPTH-1:0] stall,
  input  logic [DEPTH-1:0] flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] occupancy,
  output logic [31:0]      perf_stall_cnt,
  output logic [31:0]      perf_flush_cnt
);

  // Stage state
  logic [DEPTH-1:0]            r_valid;
  logic [DEPTH-1:0][WIDTH-1:0] r_data;
  logic [CNT_W-1:0]            r_occ;

  // Handshake network
  logic [DEPTH-1:0]            w_sink_rdy;   // sink of stage i can take its item
  logic [DEPTH-1:0]            w_move;       // stage i hands its item on this edge
  logic [DEPTH-1:0]            w_can_load;   // stage i can be written this edge
  logic                        w_in_xfer;

  // Data arriving at each stage
  logic [DEPTH-1:0]            w_up_take;    // something arrives at stage i
  logic [DEPTH-1:0]            w_up_live;    // arriving item was not flushed upstream
  logic [DEPTH-1:0][WIDTH-1:0] w_up_data;

  // Next state
  logic [DEPTH-1:0]            w_nxt_valid;
  logic [DEPTH-1:0][WIDTH-1:0] w_nxt_data;
  logic [CNT_W-1:0]            w_nxt_occ;

  // Readiness ripples from the tail toward stage 0 so a moving stage frees its slot in the same cycle
  always_comb begin
    w_sink_rdy = '0;
    w_move     = '0;
    w_can_load = '0;
    w_sink_rdy[DEPTH-1] = out_ready;
    for (int i = DEPTH - 1; i > 0; i--) begin
      w_move[i]       = r_valid[i] & ~stall[i] & w_sink_rdy[i];
      w_can_load[i]   = ~stall[i] & (~r_valid[i] | w_move[i]);
      w_sink_rdy[i-1] = w_can_load[i];
    end
    w_move[0]     = r_valid[0] & ~stall[0] & w_sink_rdy[0];
    w_can_load[0] = ~stall[0] & (~r_valid[0] | w_move[0]);
  end

  assign in_ready  = w_can_load[0];
  assign w_in_xfer = in_valid & w_can_load[0];

  // Gather what each stage would receive: the input port for stage 0, the previous stage otherwise.
  // An item leaving a stage that is being flushed arrives as a bubble, so a flushed
  // (squashed) item never reappears further down the chain.
  always_comb begin
    w_up_take    = '0;
    w_up_live    = '0;
    w_up_data    = '0;
    w_up_take[0] = w_in_xfer;
    w_up_live[0] = 1'b1;
    w_up_data[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      w_up_take[i] = w_move[i-1];
      w_up_live[i] = ~flush[i-1];
      w_up_data[i] = r_data[i-1];
    end
  end

  // Per-stage next state: flush, then stall, then load, then bubble, else hold
  always_comb begin
    w_nxt_valid = r_valid;
    w_nxt_data  = r_data;
    for (int i = 0; i < DEPTH; i++) begin
      if (flush[i]) begin
        w_nxt_valid[i] = 1'b0;
      end else if (stall[i]) begin
        w_nxt_valid[i] = r_valid[i];
      end else if (w_up_take[i]) begin
        w_nxt_valid[i] = w_up_live[i];
        w_nxt_data[i]  = w_up_data[i];
      end else if (w_move[i]) begin
        w_nxt_valid[i] = 1'b0;
      end
    end
  end

  // Population count of the next valid vector, so occupancy is a plain register
  always_comb begin
    w_nxt_occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_nxt_occ = w_nxt_occ + CNT_W'(w_nxt_valid[i]);
    end
  end

  // Stage registers and occupancy; reset discards everything in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_data  <= '0;
      r_occ   <= '0;
    end else begin
      r_valid <= w_nxt_valid;
      r_data  <= w_nxt_data;
      r_occ   <= w_nxt_occ;
    end
  end

  assign out_valid = r_valid[DEPTH-1];
  assign out_data  = r_data[DEPTH-1];
  assign occupancy = r_occ;

`ifdef PIPE_STAGE_CHAIN_PERF_EN
  logic [31:0] r_perf_stall_cnt;
  logic [31:0] r_perf_flush_cnt;
  logic        w_stall_hit;
  logic        w_flush_hit;

  // A cycle counts once no matter how many stages are hit
  assign w_stall_hit = |(stall & r_valid);
  assign w_flush_hit = |(flush & r_valid);

  // Saturating event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_stall_cnt <= '0;
      r_perf_flush_cnt <= '0;
    end else begin
      if (w_stall_hit && (r_perf_stall_cnt != 32'hFFFF_FFFF)) begin
        r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      end
      if (w_flush_hit && (r_perf_flush_cnt != 32'hFFFF_FFFF)) begin
        r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
      end
    end
  end

  assign perf_stall_cnt = r_perf_stall_cnt;
  assign perf_flush_cnt = r_perf_flush_cnt;
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Testbench for pipe_stage_chain (DEPTH=4, WIDTH=8): directed scenarios plus a
// random phase, checked each cycle against a conveyor-belt model of the chain.
module tb_pipe_stage_chain;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic [D-1:0]  stall;
  logic [D-1:0]  flush;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
  logic [CW-1:0] occupancy;
  logic [31:0]   perf_stall_cnt;
  logic [31:0]   perf_flush_cnt;

  pipe_stage_chain #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .stall(stall), .flush(flush),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy),
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: slot i holds an item when m_vld[i]
  logic          m_vld[D];
  logic [W-1:0]  m_dat[D];
  int unsigned   m_stall_cnt;
  int unsigned   m_flush_cnt;
  logic [W-1:0]  cap[$];   // items seen leaving the chain
  logic [W-1:0]  acc[$];   // items the chain accepted

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      m_vld[i] = 1'b0;
      m_dat[i] = '0;
    end
    m_stall_cnt = 0;
    m_flush_cnt = 0;
  endtask

  // One clock cycle: drive, check outputs against the model, advance the model
  task automatic step(input logic iv, input logic [W-1:0] id, input logic [D-1:0] st,
                      input logic [D-1:0] fl, input logic ordy);
    logic         nv[D];
    logic [W-1:0] nd[D];
    logic         kill[D];
    logic         exp_rdy;
    logic         any_s;
    logic         any_f;
    int           cnt;
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    stall     = st;
    flush     = fl;
    out_ready = ordy;
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_vld[D-1]));
    if (m_vld[D-1]) chk("out_data", 32'(out_data), 32'(m_dat[D-1]));
    cnt = 0;
    for (int i = 0; i < D; i++) cnt += int'(m_vld[i]);
    chk("occupancy", 32'(occupancy), 32'(cnt));
`ifdef PIPE_STAGE_CHAIN_PERF_EN
    chk("perf_stall_cnt", perf_stall_cnt, m_stall_cnt);
    chk("perf_flush_cnt", perf_flush_cnt, m_flush_cnt);
`else
    chk("perf_stall_cnt", perf_stall_cnt, 32'd0);
    chk("perf_flush_cnt", perf_flush_cnt, 32'd0);
`endif
    // Advance items downstream-first, like a conveyor belt
    any_s = 1'b0;
    any_f = 1'b0;
    for (int i = 0; i < D; i++) begin
      nv[i]   = m_vld[i];
      nd[i]   = m_dat[i];
      kill[i] = 1'b0;
      any_s   = any_s | (m_vld[i] & st[i]);
      any_f   = any_f | (m_vld[i] & fl[i]);
    end
    for (int i = D - 1; i >= 0; i--) begin
      if (m_vld[i] && !st[i]) begin
        if (i == D - 1) begin
          if (ordy) nv[i] = 1'b0;
        end else if (!nv[i+1] && !st[i+1]) begin
          nv[i+1]   = 1'b1;
          nd[i+1]   = m_dat[i];
          kill[i+1] = fl[i];
          nv[i]     = 1'b0;
        end
      end
    end
    exp_rdy = !st[0] && !nv[0];
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (out_valid && ordy && !st[D-1]) cap.push_back(out_data);
    if (iv && in_ready) acc.push_back(id);
    if (iv && exp_rdy) begin
      nv[0] = 1'b1;
      nd[0] = id;
    end
    for (int i = 0; i < D; i++) begin
      if (fl[i] || kill[i]) nv[i] = 1'b0;
      m_vld[i] = nv[i];
      m_dat[i] = nd[i];
    end
    if (any_s && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
    if (any_f && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, '0, '0, 1'b1);
  endtask

  task automatic cmp_cap_acc(input string tag);
    chk({tag, "_count"}, 32'(cap.size()), 32'(acc.size()));
    for (int i = 0; i < cap.size() && i < acc.size(); i++) chk(tag, 32'(cap[i]), 32'(acc[i]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] exp1[3];
    exp1[0] = 8'h11; exp1[1] = 8'h22; exp1[2] = 8'h33;

    // Reset state
    rst = 1'b1; in_valid = 1'b0; in_data = '0; stall = '0; flush = '0; out_ready = 1'b0;
    model_reset();
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_perf_stall", perf_stall_cnt, 32'd0);
    chk("rst_perf_flush", perf_flush_cnt, 32'd0);
    stall = 4'b0001;
    #1;
    chk("rst_in_ready_stall0", 32'(in_ready), 32'd0);
    stall = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Basic latency and ordering
    cap.delete(); acc.delete();
    step(1'b1, 8'h11, '0, '0, 1'b1);
    step(1'b1, 8'h22, '0, '0, 1'b1);
    step(1'b1, 8'h33, '0, '0, 1'b1);
    idle(6);
    chk("basic_count", 32'(cap.size()), 32'd3);
    for (int i = 0; i < cap.size() && i < 3; i++) chk("basic_data", 32'(cap[i]), 32'(exp1[i]));

    // Fill under backpressure, then drain
    cap.delete(); acc.delete();
    for (int k = 0; k < 4; k++) step(1'b1, 8'hA0 + 8'(k), '0, '0, 1'b0);
    step(1'b1, 8'hA4, '0, '0, 1'b0);
    step(1'b1, 8'hA4, '0, '0, 1'b0);
    chk("fill_accepted", 32'(acc.size()), 32'd4);
    idle(6);
    cmp_cap_acc("fill_drain");

    // Continuous stream with stall[1] for two cycles
    cap.delete(); acc.delete();
    for (int k = 0; k < 12; k++)
      step(1'b1, 8'h30 + 8'(k), (k == 3 || k == 4) ? 4'b0010 : 4'b0000, '0, 1'b1);
    idle(8);
    cmp_cap_acc("stall_stream");

    // Flush stages 0,1 while an input arrives
    cap.delete(); acc.delete();
    step(1'b1, 8'h51, '0, '0, 1'b1);
    step(1'b1, 8'h52, '0, '0, 1'b1);
    step(1'b1, 8'h53, '0, '0, 1'b1);
    step(1'b1, 8'h54, '0, 4'b0011, 1'b1);
    @(posedge clk); #1;
    chk("flush_occupancy", 32'(occupancy), 32'd1);
    idle(6);
    chk("flush_count", 32'(cap.size()), 32'd1);
    if (cap.size() > 0) chk("flush_data", 32'(cap[0]), 32'h51);

    // Flush and stall together on stage 2
    cap.delete(); acc.delete();
    step(1'b1, 8'h61, '0, '0, 1'b1);
    step(1'b1, 8'h62, '0, '0, 1'b1);
    step(1'b1, 8'h63, '0, '0, 1'b1);
    step(1'b0, 8'h00, 4'b0100, 4'b0100, 1'b1);
    @(posedge clk); #1;
    chk("flstall_occupancy", 32'(occupancy), 32'd2);
    idle(8);
    chk("flstall_count", 32'(cap.size()), 32'd2);
    if (cap.size() == 2) begin
      chk("flstall_data0", 32'(cap[0]), 32'h62);
      chk("flstall_data1", 32'(cap[1]), 32'h63);
    end

    // Asynchronous reset mid-stream
    for (int k = 0; k < 5; k++) step(1'b1, 8'h71 + 8'(k), '0, '0, 1'b1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_occupancy", 32'(occupancy), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    model_reset();
    cap.delete(); acc.delete();
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    idle(6);
    chk("arst_no_output", 32'(cap.size()), 32'd0);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      logic [D-1:0] st;
      logic [D-1:0] fl;
      for (int b = 0; b < D; b++) begin
        st[b] = ($urandom_range(0, 7) == 0);
        fl[b] = ($urandom_range(0, 15) == 0);
      end
      step($urandom_range(0, 3) != 0, 8'($urandom), st, fl, $urandom_range(0, 3) != 0);
    end
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised chain of DEPTH pipeline registers, each WIDTH bits wide, with a valid bit, valid/ready backpressure, per-stage stall and per-stage flush.
- Replaces hand-written inter-stage register blocks (IF/ID, ID/EX, EX/MEM, MEM/WB) in the CPU top level.
- Adds bubble insertion, hazard stalls and branch flushes, which the current fixed registers cannot do.
- One instance per datapath bundle; the core controller drives the stall and flush vectors.

Parameters:
- WIDTH, 64, data bits per stage.
- DEPTH, 4, number of register stages; legal range 1..16.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream data valid
- in_data  input  WIDTH  upstream data
- in_ready  output  1  stage 0 can accept this cycle
- stall  input  DEPTH  bit i holds stage i
- flush  input  DEPTH  bit i invalidates stage i at the next edge
- out_valid  output  1  stage DEPTH-1 holds valid data
- out_data  output  WIDTH  stage DEPTH-1 data
- out_ready  input  1  downstream accepts
- occupancy  output  CNT_W  number of valid stages
- perf_stall_cnt  output  32  stall counter (optional feature)
- perf_flush_cnt  output  32  flush counter (optional feature)

Behaviour:
- Reset (async, rst=1): every valid_i=0 and every data_i=0. out_valid=0, out_data=0, occupancy=0, both perf counters=0. in_ready=1 immediately, unless stall[0]=1. Reset mid-stream discards all contents, with no partial output.
- Stage i "moves" at an edge when valid_i=1, stall[i]=0, and the sink can take it.
  - Sink for i<DEPTH-1 is stage i+1; for i=DEPTH-1 the sink is out_ready.
- Stage i "can_load" when stall[i]=0 and (valid_i=0 or stage i moves). This gives full-throughput pass-through, evaluated combinationally from the last stage back to the first.
- in_ready = can_load(0). An input transfer occurs when in_valid=1 and in_ready=1.
- Next-state per stage, in priority order:
  1. flush[i]=1 → valid_i=0; data_i is unchanged. Any data arriving this cycle is discarded, but the upstream transfer still counts as consumed.
  2. stall[i]=1 → hold valid_i and data_i.
  3. can_load(i) and upstream stage moves, or in transfer for i=0 → load the upstream data, valid_i=1.
  4. Stage moves with no incoming data → valid_i=0 (bubble).
  5. Otherwise → hold.
- Bubble insertion: a stalled stage i with a moving stage i+1 leaves valid_{i+1}=0.
- Downstream is not stalled by a stalled upstream stage.
- A valid stage whose downstream neighbour is stalled holds its data; there is no overwrite.
- Latency: with no stalls, flushes or backpressure, data presented with in_valid in cycle t appears with out_valid in cycle t+DEPTH. Throughput is 1 per cycle.
- out_data is a register output, never combinational from in_data.
- out_valid=0 → out_data holds stale content; consumers must qualify it with out_valid.
- occupancy is a registered count of valid_i bits, updated each edge. It stays within 0..DEPTH.
- Simultaneous flush and stall on the same stage: flush wins.
- flush=all-ones: every stage is empty after the next edge. The in transfer in that cycle is dropped.

Optional Feature:
- Macro PIPE_STAGE_CHAIN_PERF_EN.
- Defined:
  - perf_stall_cnt increments by 1 each cycle in which any stall bit is set while the corresponding stage is valid.
  - perf_flush_cnt increments by 1 each cycle in which any flush bit hits a valid stage.
  - Both counters saturate at 32'hFFFFFFFF, clear on rst, and each increments at most once per cycle.
- Undefined: both ports are tied to 0 and no counter flops are synthesised.

Test Plan:
- DEPTH=4, WIDTH=8; after rst, push 8'h11, 8'h22, 8'h33 on consecutive cycles with out_ready=1 → out_valid in cycles 4,5,6 with data 11,22,33; occupancy peaks at 3 (in cycle 3), then decrements.
- Fill with 8'hA0..A3 and hold out_ready=0 → in_ready=0 once occupancy=4. Raise out_ready → drains A0,A1,A2,A3 in order, with no loss or duplication.
- Stream continuously; assert stall[1] for 2 cycles → two bubbles emerge at the output, stage 0 holds, order is preserved, perf_stall_cnt=2 when the macro is defined.
- Stages 0..2 valid; assert flush=4'b0011 in the same cycle as in_valid=1 → the input is consumed but dropped; only the old stage-2 item is output; occupancy drops to 1.
- flush[2] and stall[2] together on a valid stage → stage 2 is invalidated, not held.
- Assert rst asynchronously mid-stream between edges → out_valid=0 and occupancy=0 immediately, without waiting for clk; no item emerges after release until new input is pushed.
